// File: rtl/camera_frame_writer.sv
// camera_frame_writer
//   Takes a pixel stream from a camera capture block and decimates it 2:1 in
//   both directions. It converts each kept pixel from RGB565 to 12-bit data
//   and writes it into one half of a ping-pong frame buffer. Buffers swap on
//   every end-of-frame pulse. After reset nothing is written until the first
//   end-of-frame pulse, so a partial frame is never stored.
//
//   Optional build macro: CAMERA_WRITER_GRAYSCALE_EN
//     undefined : wr_data_out = {R[4:1], G[5:2], B[4:1]}
//     defined   : wr_data_out = {L, L, L}, where L = ((2R + 2G + 2B) mod 256) >> 4
//
//   Parameters
//     OUT_WIDTH   stored columns per frame (after decimation)
//     OUT_HEIGHT  stored rows per frame (after decimation)
//     ADDR_WIDTH  write address width
//
//   Ports
//     pixel_clock_in    sole clock, rising edge
//     rst_in            asynchronous active-high reset
//     frame_x_count_in  column index + 1 on valid cycles
//     frame_y_count_in  row index
//     pixel_data_in     RGB565 pixel {R[15:11], G[10:5], B[4:0]}
//     pixel_valid_in    pixel qualifier
//     frame_done_in     single-cycle end-of-frame pulse
//     wr_addr_out       frame buffer write address (holds while idle)
//     wr_data_out       12-bit write data (holds while idle)
//     wr_en_out         write strobe, one cycle after an accepted pixel
//     wr_buffer_out     ping-pong buffer currently being written
//     rd_buffer_out     last completed buffer, for display
//     frame_count_out   completed-frame counter, wraps modulo 256
module camera_frame_writer #(
   parameter int unsigned OUT_WIDTH  = 320,
   parameter int unsigned OUT_HEIGHT = 240,
   parameter int unsigned ADDR_WIDTH = 17
) (
   input  logic                  pixel_clock_in,
   input  logic                  rst_in,
   input  logic [9:0]            frame_x_count_in,
   input  logic [8:0]            frame_y_count_in,
   input  logic [15:0]           pixel_data_in,
   input  logic                  pixel_valid_in,
   input  logic                  frame_done_in,
   output logic [ADDR_WIDTH-1:0] wr_addr_out,
   output logic [11:0]           wr_data_out,
   output logic                  wr_en_out,
   output logic                  wr_buffer_out,
   output logic                  rd_buffer_out,
   output logic [7:0]            frame_count_out
);

   localparam int unsigned COL_W  = 10;
   localparam int unsigned ROW_W  = 9;
   localparam int unsigned CALC_W = 32;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      CAPTURE   = 2'd1,
      SWAP      = 2'd2
   } state_t;

   state_t state;

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [COL_W-2:0]  col_half;
   logic [ROW_W-2:0]  row_half;
   logic              pixel_accept_c;
   logic              pixel_in_range_c;
   logic [CALC_W-1:0] addr_full_c;
   logic [11:0]       pixel_conv_c;

   // Column counter runs one ahead; x_count = 0 wraps to col = 1023 (odd, so dropped).
   assign col      = frame_x_count_in - COL_W'(1);
   assign row      = frame_y_count_in;
   assign col_half = col[COL_W-1:1];
   assign row_half = row[ROW_W-1:1];

   // Keep only even columns of even rows while a frame is being captured.
   assign pixel_accept_c   = pixel_valid_in && (state == CAPTURE) && !col[0] && !row[0];
   assign pixel_in_range_c = (CALC_W'(col_half) < OUT_WIDTH) && (CALC_W'(row_half) < OUT_HEIGHT);

   // Linear address; the default 320-wide frame uses row*256 + row*64.
   generate
      if (OUT_WIDTH == 320) begin : g_addr_shift_add
         assign addr_full_c = (CALC_W'(row_half) << 8) + (CALC_W'(row_half) << 6)
                            + CALC_W'(col_half);
      end else begin : g_addr_mult
         assign addr_full_c = (CALC_W'(row_half) * CALC_W'(OUT_WIDTH)) + CALC_W'(col_half);
      end
   endgenerate

`ifdef CAMERA_WRITER_GRAYSCALE_EN
   // Equal-weight luma: the doubled channel sum wraps at 8 bits, top nibble kept.
   logic [7:0] luma_sum_c;
   assign luma_sum_c   = 8'({pixel_data_in[15:11], 1'b0})
                       + 8'({pixel_data_in[10:5], 1'b0})
                       + 8'({pixel_data_in[4:0], 1'b0});
   assign pixel_conv_c = {luma_sum_c[7:4], luma_sum_c[7:4], luma_sum_c[7:4]};
`else
   // RGB565 -> RGB444 by dropping channel LSBs.
   assign pixel_conv_c = {pixel_data_in[15:12], pixel_data_in[10:7], pixel_data_in[4:1]};
`endif

   // Bits that are not needed in every configuration.
   logic unused_bits;
   assign unused_bits = ^{pixel_data_in, addr_full_c};

   // Frame sequencing and the registered write port.
   always_ff @(posedge pixel_clock_in or posedge rst_in) begin
      if (rst_in) begin
         state           <= WAIT_SYNC;
         wr_en_out       <= 1'b0;
         wr_addr_out     <= '0;
         wr_data_out     <= '0;
         wr_buffer_out   <= 1'b0;
         rd_buffer_out   <= 1'b1;
         frame_count_out <= '0;
      end else begin
         wr_en_out <= 1'b0;
         if (pixel_accept_c && pixel_in_range_c) begin
            wr_en_out   <= 1'b1;
            wr_addr_out <= ADDR_WIDTH'(addr_full_c);
            wr_data_out <= pixel_conv_c;
         end

         case (state)
            WAIT_SYNC: begin
               if (frame_done_in) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (frame_done_in) begin
                  state           <= SWAP;
                  rd_buffer_out   <= wr_buffer_out;
                  wr_buffer_out   <= ~wr_buffer_out;
                  frame_count_out <= frame_count_out + 8'd1;
               end
            end
            SWAP: begin
               state <= CAPTURE;
            end
            default: begin
               state <= WAIT_SYNC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Scoreboard bench for camera_frame_writer: the stimulus side steps a frame-level
// model and queues the expected outputs of every cycle; a monitor compares them.
module tb_camera_frame_writer;

   logic        pixel_clock_in;
   logic        rst_in;
   logic [9:0]  frame_x_count_in;
   logic [8:0]  frame_y_count_in;
   logic [15:0] pixel_data_in;
   logic        pixel_valid_in;
   logic        frame_done_in;
   logic [16:0] wr_addr_out;
   logic [11:0] wr_data_out;
   logic        wr_en_out;
   logic        wr_buffer_out;
   logic        rd_buffer_out;
   logic [7:0]  frame_count_out;

   camera_frame_writer dut (
      .pixel_clock_in   (pixel_clock_in),
      .rst_in           (rst_in),
      .frame_x_count_in (frame_x_count_in),
      .frame_y_count_in (frame_y_count_in),
      .pixel_data_in    (pixel_data_in),
      .pixel_valid_in   (pixel_valid_in),
      .frame_done_in    (frame_done_in),
      .wr_addr_out      (wr_addr_out),
      .wr_data_out      (wr_data_out),
      .wr_en_out        (wr_en_out),
      .wr_buffer_out    (wr_buffer_out),
      .rd_buffer_out    (rd_buffer_out),
      .frame_count_out  (frame_count_out)
   );

   initial pixel_clock_in = 1'b0;
   always #5 pixel_clock_in = ~pixel_clock_in;

   typedef struct {
      int due;
      bit en;
      int addr;
      int data;
      bit wrb;
      bit rdb;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Model state: frame-level view of the writer.
   bit m_synced, m_swap, m_wrb, m_rdb;
   int m_cnt, m_addr, m_data;

   always @(posedge pixel_clock_in) cyc <= cyc + 1;

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int exp_data(input logic [15:0] p);
      int r, g, b, l;
      r = int'(p[15:11]);
      g = int'(p[10:5]);
      b = int'(p[4:0]);
`ifdef CAMERA_WRITER_GRAYSCALE_EN
      l = ((2 * r + 2 * g + 2 * b) % 256) / 16;
      return l * 256 + l * 16 + l;
`else
      return (r / 2) * 256 + (g / 4) * 16 + (b / 2);
`endif
   endfunction

   task automatic model_reset();
      m_synced = 0; m_swap = 0; m_wrb = 0; m_rdb = 1;
      m_cnt = 0; m_addr = 0; m_data = 0;
   endtask

   // One input cycle: drive, then queue what the outputs must show after the edge.
   task automatic drive(input bit v, input int x, input int y, input logic [15:0] d,
                        input bit done);
      exp_t e;
      int col, row;
      bit wr;
      @(negedge pixel_clock_in);
      pixel_valid_in   = v;
      frame_x_count_in = 10'(x);
      frame_y_count_in = 9'(y);
      pixel_data_in    = d;
      frame_done_in    = done;
      col = (x + 1023) % 1024;
      row = y;
      wr  = v && m_synced && !m_swap && (col % 2 == 0) && (row % 2 == 0)
            && (col / 2 < 320) && (row / 2 < 240);
      if (wr) begin
         m_addr = ((row / 2) * 320 + col / 2) % (1 << 17);
         m_data = exp_data(d);
      end
      if (m_swap) begin
         m_swap = 0;
      end else if (done) begin
         if (!m_synced) begin
            m_synced = 1;
         end else begin
            m_rdb  = m_wrb;
            m_wrb  = !m_wrb;
            m_cnt  = (m_cnt + 1) % 256;
            m_swap = 1;
         end
      end
      e.due = cyc + 1; e.en = wr; e.addr = m_addr; e.data = m_data;
      e.wrb = m_wrb; e.rdb = m_rdb; e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0000, 0);
   endtask

   task automatic pix(input int x, input int y, input logic [15:0] d);
      drive(1, x, y, d, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_wr_en"},   wr_en_out, 0);
      check({tag, "_addr"},    wr_addr_out, 0);
      check({tag, "_data"},    wr_data_out, 0);
      check({tag, "_wr_buf"},  wr_buffer_out, 0);
      check({tag, "_rd_buf"},  rd_buffer_out, 1);
      check({tag, "_fcount"},  frame_count_out, 0);
   endtask

   // Monitor: compares every queued cycle when it falls due.
   always @(negedge pixel_clock_in) begin
      if (!rst_in) begin
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            void'(exp_q.pop_front());
            check("missed_cycle", 1, 0);
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_en",   wr_en_out, e.en);
            check("wr_addr", wr_addr_out, e.addr);
            check("wr_data", wr_data_out, e.data);
            check("wr_buf",  wr_buffer_out, e.wrb);
            check("rd_buf",  rd_buffer_out, e.rdb);
            check("fcount",  frame_count_out, e.cnt);
         end else if (wr_en_out) begin
            check("unexpected_write", 1, 0);
         end
      end
   end

   initial begin
      rst_in = 1'b1;
      pixel_valid_in = 0; frame_x_count_in = 0; frame_y_count_in = 0;
      pixel_data_in = 0; frame_done_in = 0;
      model_reset();
      #1 check_reset_values("reset0");
      repeat (3) @(negedge pixel_clock_in);
      rst_in = 1'b0;

      // Pixels before the first sync pulse are never written.
      for (int i = 0; i < 20; i++)
         pix(2 * $urandom_range(0, 319) + 1, 2 * $urandom_range(0, 239), 16'($urandom));
      idle(2);
      check("presync_fcount", frame_count_out, 0);

      // Sync, then directed corner pixels.
      drive(0, 0, 0, 0, 1);
      pix(1, 0, 16'hFFFF);
      pix(639, 478, 16'hF800);
      pix(643, 479, 16'hF800);
      pix(2, 0, 16'h1234);
      pix(1, 1, 16'h1234);
      pix(0, 0, 16'hABCD);
      pix(641, 0, 16'h5555);
      pix(1, 480, 16'h5555);
      pix(3, 2, 16'h07E0);
      idle(2);

      // Three frames in a row; second pulse during SWAP is ignored.
      for (int f = 0; f < 3; f++) begin
         drive(0, 0, 0, 0, 1);
         drive(0, 0, 0, 0, 1);
         pix(5, 4, 16'($urandom));
      end
      // Pixel coinciding with end-of-frame is still written, then swap.
      drive(1, 1, 2, 16'h0F0F, 1);
      pix(7, 6, 16'hC3A5);

      // Randomized traffic with occasional frame ends.
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 700), $urandom_range(0, 500),
               16'($urandom), $urandom_range(0, 39) == 0);

      // Enough frames to wrap the frame counter.
      for (int f = 0; f < 260; f++) begin
         drive(0, 0, 0, 0, 1);
         idle(1);
      end
      pix(9, 8, 16'h8421);
      pix(11, 10, 16'hFFFF);

      // Mid-frame reset: asynchronous, then no writes until the next sync.
      @(posedge pixel_clock_in);
      #2 rst_in = 1'b1;
      exp_q.delete();
      model_reset();
      #1 check_reset_values("reset_mid");
      repeat (2) @(negedge pixel_clock_in);
      rst_in = 1'b0;
      for (int i = 0; i < 10; i++)
         pix(2 * $urandom_range(0, 319) + 1, 2 * $urandom_range(0, 239), 16'($urandom));
      drive(1, 1, 0, 16'hFFFF, 1);
      pix(21, 20, 16'h7BEF);
      for (int i = 0; i < 100; i++)
         drive(1, $urandom_range(0, 660), $urandom_range(0, 490), 16'($urandom),
               $urandom_range(0, 29) == 0);
      idle(2);

      repeat (2) @(negedge pixel_clock_in);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
